// File: rtl/xif_coproc_responder.sv
// CV-X-IF coprocessor responder: CADD, CHAM and optional CMUL on custom-0.
// Define XIF_COPROC_MUL_EN to build the 32-cycle shift-add CMUL datapath.
module xif_coproc_responder #(
   parameter int X_ID_WIDTH = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  x_issue_valid_i,
   output logic                  x_issue_ready_o,
   input  logic [31:0]           x_issue_instr_i,
   input  logic [X_ID_WIDTH-1:0] x_issue_id_i,
   input  logic [31:0]           x_issue_rs1_i,
   input  logic [31:0]           x_issue_rs2_i,
   input  logic [1:0]            x_issue_rs_valid_i,
   output logic                  x_issue_accept_o,
   output logic                  x_issue_writeback_o,
   input  logic                  x_commit_valid_i,
   input  logic [X_ID_WIDTH-1:0] x_commit_id_i,
   input  logic                  x_commit_kill_i,
   output logic                  x_result_valid_o,
   input  logic                  x_result_ready_i,
   output logic [X_ID_WIDTH-1:0] x_result_id_o,
   output logic [31:0]           x_result_data_o,
   output logic [4:0]            x_result_rd_o,
   output logic                  x_result_we_o
);

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   state_t                state_q;
   logic                  committed_q;
   logic [X_ID_WIDTH-1:0] id_q;
   logic [4:0]            rd_q;
   logic [31:0]           data_q;
`ifdef XIF_COPROC_MUL_EN
   logic [31:0]           ma_q;
   logic [31:0]           mb_q;
   logic [4:0]            cnt_q;
`endif

   logic        is_cx;
   logic        hit_add;
   logic        hit_mul;
   logic        hit_ham;
   logic [31:0] diff;
   logic [5:0]  ham;
   logic        issue_fire;
   logic        commit_hit;
   logic        unused_fields;

   assign is_cx = (x_issue_instr_i[6:0] == 7'b0001011) &&
                  (x_issue_instr_i[31:25] == 7'b0000000);
   assign hit_add = is_cx && (x_issue_instr_i[14:12] == 3'b000);
   assign hit_ham = is_cx && (x_issue_instr_i[14:12] == 3'b010);
`ifdef XIF_COPROC_MUL_EN
   assign hit_mul = is_cx && (x_issue_instr_i[14:12] == 3'b001);
`else
   assign hit_mul = 1'b0;
`endif
   assign unused_fields = ^x_issue_instr_i[24:15];

   assign x_issue_accept_o    = (hit_add | hit_mul | hit_ham) &&
                                (x_issue_rs_valid_i == 2'b11);
   assign x_issue_writeback_o = x_issue_accept_o;
   assign x_issue_ready_o     = ~rst_i & (state_q == IDLE);

   assign diff = x_issue_rs1_i ^ x_issue_rs2_i;
   always_comb begin
      ham = '0;
      for (int i = 0; i < 32; i++) begin
         ham = ham + {5'd0, diff[i]};
      end
   end

   assign issue_fire = x_issue_valid_i & x_issue_accept_o & (state_q == IDLE);
   // While idle the only id that can be committed is the one being issued.
   assign commit_hit = x_commit_valid_i &&
      (x_commit_id_i == ((state_q == IDLE) ? x_issue_id_i : id_q));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         committed_q <= 1'b0;
         id_q        <= '0;
         rd_q        <= '0;
         data_q      <= '0;
`ifdef XIF_COPROC_MUL_EN
         ma_q        <= '0;
         mb_q        <= '0;
         cnt_q       <= '0;
`endif
      end else begin
         if (state_q != IDLE && commit_hit && !x_commit_kill_i) begin
            committed_q <= 1'b1;
         end
         unique case (state_q)
            IDLE: begin
               if (issue_fire) begin
                  id_q        <= x_issue_id_i;
                  rd_q        <= x_issue_instr_i[11:7];
                  committed_q <= commit_hit & ~x_commit_kill_i;
                  if (commit_hit && x_commit_kill_i) begin
                     state_q <= IDLE;
`ifdef XIF_COPROC_MUL_EN
                  end else if (hit_mul) begin
                     ma_q    <= x_issue_rs1_i;
                     mb_q    <= x_issue_rs2_i;
                     cnt_q   <= '0;
                     data_q  <= '0;
                     state_q <= EXEC;
`endif
                  end else begin
                     data_q  <= hit_add ? x_issue_rs1_i + x_issue_rs2_i
                                        : {26'd0, ham};
                     state_q <= DONE;
                  end
               end
            end
`ifdef XIF_COPROC_MUL_EN
            EXEC: begin
               if (commit_hit && x_commit_kill_i && !committed_q) begin
                  state_q <= IDLE;
               end else begin
                  data_q <= data_q + (mb_q[0] ? ma_q : 32'd0);
                  ma_q   <= ma_q << 1;
                  mb_q   <= mb_q >> 1;
                  cnt_q  <= cnt_q + 5'd1;
                  if (cnt_q == 5'd31) begin
                     state_q <= DONE;
                  end
               end
            end
`endif
            DONE: begin
               if (commit_hit && x_commit_kill_i && !committed_q) begin
                  state_q <= IDLE;
               end else if (x_result_valid_o && x_result_ready_i) begin
                  committed_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign x_result_valid_o = (state_q == DONE) & committed_q;
   assign x_result_we_o    = x_result_valid_o;
   assign x_result_id_o    = id_q;
   assign x_result_data_o  = data_q;
   assign x_result_rd_o    = rd_q;

endmodule

// File: tb/tb_xif_coproc_responder.sv
// Scoreboard bench for xif_coproc_responder: directed issue/commit vectors.
// CMUL expectations follow XIF_COPROC_MUL_EN.
module tb_xif_coproc_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        iv = 1'b0;
   logic        irdy;
   logic [31:0] instr = '0;
   logic [3:0]  iid = '0;
   logic [31:0] rs1 = '0;
   logic [31:0] rs2 = '0;
   logic [1:0]  rsv = '0;
   logic        acc;
   logic        wb;
   logic        cv = 1'b0;
   logic [3:0]  cid = '0;
   logic        ckill = 1'b0;
   logic        rv;
   logic        rrdy = 1'b1;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [4:0]  rrd;
   logic        rwe;

`ifdef XIF_COPROC_MUL_EN
   localparam bit MUL = 1'b1;
`else
   localparam bit MUL = 1'b0;
`endif

   xif_coproc_responder #(.X_ID_WIDTH(4)) dut (
      .clk_i(clk), .rst_i(rst),
      .x_issue_valid_i(iv), .x_issue_ready_o(irdy),
      .x_issue_instr_i(instr), .x_issue_id_i(iid),
      .x_issue_rs1_i(rs1), .x_issue_rs2_i(rs2),
      .x_issue_rs_valid_i(rsv), .x_issue_accept_o(acc),
      .x_issue_writeback_o(wb),
      .x_commit_valid_i(cv), .x_commit_id_i(cid),
      .x_commit_kill_i(ckill),
      .x_result_valid_o(rv), .x_result_ready_i(rrdy),
      .x_result_id_o(rid), .x_result_data_o(rdata),
      .x_result_rd_o(rrd), .x_result_we_o(rwe)
   );

   typedef struct {
      logic [31:0] data;
      logic [3:0]  id;
      logic [4:0]  rd;
      int          first;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   logic prev_v = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (rv === 1'b1) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_result: got valid=1 data %h expected no result", rdata);
         end else begin
            if (!prev_v && sb[0].first >= 0)
               chk("first_valid_cycle", cyc, sb[0].first);
            chk("result_data", rdata, sb[0].data);
            chk("result_id", {28'd0, rid}, {28'd0, sb[0].id});
            chk("result_rd", {27'd0, rrd}, {27'd0, sb[0].rd});
            chk("result_we", {31'd0, rwe}, 32'd1);
            if (rrdy) void'(sb.pop_front());
         end
      end
      prev_v = rv;
   end

   function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] rd);
      return {7'b0, 5'd2, 5'd1, f3, rd, 7'b0001011};
   endfunction

   task automatic wait_until(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic issue(input logic [2:0] f3, input logic [4:0] rd,
                        input logic [3:0] id, input logic [31:0] a,
                        input logic [31:0] b, input logic [1:0] v,
                        input bit exp_acc, input bit commit_now,
                        output int h);
      instr = mk(f3, rd);
      iid = id;
      rs1 = a;
      rs2 = b;
      rsv = v;
      iv = 1'b1;
      if (commit_now) begin
         cv = 1'b1;
         cid = id;
         ckill = 1'b0;
      end
      #1;
      chk("issue_ready", {31'd0, irdy}, 32'd1);
      chk("accept", {31'd0, acc}, {31'd0, exp_acc});
      chk("writeback", {31'd0, wb}, {31'd0, exp_acc});
      @(posedge clk);
      #1;
      h = cyc;
      iv = 1'b0;
      cv = 1'b0;
   endtask

   task automatic commit_at(input int e, input logic [3:0] id, input bit kill);
      wait_until(e - 1);
      cv = 1'b1;
      cid = id;
      ckill = kill;
      @(posedge clk);
      #1;
      cv = 1'b0;
      ckill = 1'b0;
   endtask

   task automatic drain(input string nm);
      int k = 0;
      while (sb.size() != 0 && k < 80) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk(nm, sb.size(), 0);
      sb.delete();
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      int h;
      int c;
      // reset values
      @(negedge clk);
      chk("rst_ready", {31'd0, irdy}, 32'd0);
      chk("rst_valid", {31'd0, rv}, 32'd0);
      chk("rst_data", rdata, 32'd0);
      chk("rst_id", {28'd0, rid}, 32'd0);
      chk("rst_rd", {27'd0, rrd}, 32'd0);
      chk("rst_we", {31'd0, rwe}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("post_rst_ready", {31'd0, irdy}, 32'd1);
      @(posedge clk);
      #1;

      // CADD with same-cycle commit
      issue(3'b000, 5'd5, 4'd3, 32'hFFFF_FFFF, 32'h0000_0002, 2'b11, 1'b1, 1'b1, h);
      sb.push_back('{32'h0000_0001, 4'd3, 5'd5, h});
      chk("cadd_ready_done", {31'd0, irdy}, 32'd0);
      drain("cadd_drain");

      // CMUL, commit at N+4
      issue(3'b001, 5'd7, 4'd9, 32'h0001_0003, 32'h0000_0005, 2'b11, MUL, 1'b0, h);
      if (MUL) sb.push_back('{32'h0005_000F, 4'd9, 5'd7, h + 32});
      commit_at(h + 4, 4'd9, 1'b0);
      wait_until(h + 20);
      chk("cmul_ready_exec", {31'd0, irdy}, {31'd0, ~MUL});
      wait_until(h + 40);
      drain("cmul_drain");

      // CHAM, commit delayed 10 cycles
      issue(3'b010, 5'd12, 4'd6, 32'hF0F0_F0F0, 32'h0F0F_0F00, 2'b11, 1'b1, 1'b0, h);
      c = h + 10;
      sb.push_back('{32'h0000_001C, 4'd6, 5'd12, c});
      commit_at(c, 4'd6, 1'b0);
      drain("cham_drain");

      // CMUL killed at N+10 after an unrelated kill at N+5
      issue(3'b001, 5'd4, 4'd2, 32'h0000_0007, 32'h0000_0009, 2'b11, MUL, 1'b0, h);
      commit_at(h + 5, 4'd11, 1'b1);
      chk("kill_other_ready", {31'd0, irdy}, {31'd0, ~MUL});
      commit_at(h + 10, 4'd2, 1'b1);
      chk("kill_ready", {31'd0, irdy}, 32'd1);
      wait_until(h + 45);
      drain("kill_drain");

      // non-offloads
      issue(3'b011, 5'd1, 4'd1, 32'h1, 32'h2, 2'b11, 1'b0, 1'b1, h);
      chk("f3_011_ready", {31'd0, irdy}, 32'd1);
      issue(3'b000, 5'd1, 4'd1, 32'h1, 32'h2, 2'b01, 1'b0, 1'b1, h);
      chk("rsv_01_ready", {31'd0, irdy}, 32'd1);
      wait_until(h + 5);
      drain("nonoffload_drain");

      // result backpressure
      rrdy = 1'b0;
      issue(3'b000, 5'd31, 4'd12, 32'h1234_5678, 32'h1111_1111, 2'b11, 1'b1, 1'b1, h);
      sb.push_back('{32'h2345_6789, 4'd12, 5'd31, h});
      wait_until(h + 5);
      rrdy = 1'b1;
      drain("bp_drain");

      // reset mid-EXEC drops the instruction
      issue(3'b001, 5'd9, 4'd5, 32'h0000_0003, 32'h0000_0003, 2'b11, MUL, 1'b1, h);
      wait_until(h + 10);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_ready", {31'd0, irdy}, 32'd0);
      chk("midrst_valid", {31'd0, rv}, 32'd0);
      chk("midrst_data", rdata, 32'd0);
      chk("midrst_id", {28'd0, rid}, 32'd0);
      chk("midrst_rd", {27'd0, rrd}, 32'd0);
      chk("midrst_we", {31'd0, rwe}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("midrst_release_ready", {31'd0, irdy}, 32'd1);
      wait_until(cyc + 40);
      drain("midrst_drain");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/xif_coproc_responder.md
# xif_coproc_responder

Coprocessor-side responder for the CV-X-IF issue, commit and result interfaces driven by `ibex_top` when `XInterface` is enabled. It accepts one offloaded custom-0 instruction at a time, executes it, and returns a register writeback once the core has committed it. It sits beside `u_top` in `ibex_simple_system` and connects to the `x_issue_*`, `x_commit_*` and `x_result_*` ports. The compressed and memory interfaces are not used.

## Interface
- `X_ID_WIDTH`, default 4: width of the instruction ID.
- `clk_i`, in, 1: clock.
- `rst_i`, in, 1: asynchronous, active-high reset.
- `x_issue_valid_i`, in, 1: issue request valid.
- `x_issue_ready_o`, out, 1: responder can take an issue.
- `x_issue_instr_i`, in, 32: offloaded instruction.
- `x_issue_id_i`, in, X_ID_WIDTH: instruction ID.
- `x_issue_rs1_i`, `x_issue_rs2_i`, in, 32 each: source operands.
- `x_issue_rs_valid_i`, in, 2: operand valid flags, bit 0 = rs1, bit 1 = rs2.
- `x_issue_accept_o`, out, 1: combinational; the instruction is ours.
- `x_issue_writeback_o`, out, 1: combinational; equals `x_issue_accept_o`.
- `x_commit_valid_i`, in, 1: commit strobe.
- `x_commit_id_i`, in, X_ID_WIDTH: ID being committed.
- `x_commit_kill_i`, in, 1: 1 = squash, 0 = commit.
- `x_result_valid_o`, out, 1: result valid.
- `x_result_ready_i`, in, 1: core takes the result.
- `x_result_id_o`, out, X_ID_WIDTH: ID of the result.
- `x_result_data_o`, out, 32: writeback data.
- `x_result_rd_o`, out, 5: destination register, `instr[11:7]`.
- `x_result_we_o`, out, 1: write enable; always 1 while valid.

## Operation
- Decode (combinational): opcode `0001011`, `funct7=0000000`.
  - `funct3=000` is CADD: rs1+rs2 modulo 2^32.
  - `funct3=001` is CMUL: low 32 bits of rs1*rs2 (unsigned).
  - `funct3=010` is CHAM: popcount(rs1^rs2), 6 bits zero-extended.
- `x_issue_accept_o` = decode hit AND `rs_valid==2'b11`. All other encodings give accept=0.
- Issue handshake = `x_issue_valid_i & x_issue_ready_o`. If accept=0, the handshake is a non-offload: the responder stays in IDLE with no side effects.
- The FSM has three states:
  - IDLE: `x_issue_ready_o=1`. An accepted handshake captures id, rd, funct3 and operands. CADD and CHAM compute their result in the same cycle, then go to DONE. CMUL goes to EXEC with the 5-bit counter cleared to 0 and the accumulator cleared to 0.
  - EXEC: shift-add over rs2 bits, one bit per cycle, accumulator 32-bit modulo 2^32. After the counter reaches 31 and that step completes, go to DONE.
  - DONE: the result register is held. On the result handshake, go to IDLE.
- `x_issue_ready_o` is 0 in EXEC and DONE.
- Commit tracking uses a `committed_q` flag, cleared when an issue is accepted.
  - A commit with matching id and kill=0 sets the flag. This includes a commit in the same cycle as the issue handshake.
  - A commit with matching id and kill=1, while not yet committed, aborts: the next state is IDLE from any state and no result is produced.
  - Commits with a non-matching id are ignored.
  - A kill after commit is a protocol violation and is ignored.
- `x_result_valid_o` = (state==DONE) & `committed_q`. Both terms are registered, so there is no combinational path from inputs.
- While valid is 1 and ready is 0, the id, data and rd outputs hold stable.

## Timing
- Reset values: `x_issue_ready_o=1` (it is 0 only while `rst_i` is high), `x_result_valid_o=0`, `x_result_data_o=0`, `x_result_id_o=0`, `x_result_rd_o=0`, `x_result_we_o=0`. The state resets to IDLE and `committed_q` resets to 0.
- Reset asserted mid-operation drops the in-flight instruction silently.
- Let N be the issue handshake edge:
  - CADD and CHAM: earliest result valid in cycle N+1.
  - CMUL: earliest result valid in cycle N+33.
- A late commit delays valid to the cycle after the commit edge.
- After the result handshake edge, `x_issue_ready_o` rises in the next cycle. There is no same-cycle re-issue, so back-to-back CADD throughput is one every 2 cycles.
- A kill takes effect at the next edge; ready=1 in the following cycle.

## Configuration
- `XIF_COPROC_MUL_EN` defined: CMUL is decoded and the EXEC state and its 32-cycle datapath are built.
- Not defined: `funct3=001` returns accept=0, and the EXEC logic and counter are not synthesised. CADD and CHAM are unchanged.

## Test plan
- CADD, rs1=0xFFFFFFFF, rs2=0x00000002, id=3, rd=5, commit in the same cycle → accept=1 and writeback=1. In cycle N+1: valid=1, data=0x00000001, id=3, rd=5, we=1.
- CMUL, rs1=0x00010003, rs2=0x00000005, commit at N+4 → issue ready=0 through EXEC. In cycle N+33: valid=1, data=0x0005000F. Without `XIF_COPROC_MUL_EN`: accept=0 and no result.
- CHAM, rs1=0xF0F0F0F0, rs2=0x0F0F0F00, commit delayed 10 cycles → valid first rises at commit edge +1, data=0x0000001C.
- CMUL issued, then commit with kill=1 at N+10 → no valid ever; ready=1 at N+11. An unrelated-id kill at N+5 has no effect.
- `funct3=011` or `rs_valid=2'b01` → accept=0, ready stays 1, no result.
- Result backpressure (ready=0 for 5 cycles) → data, id and rd stable. Assert `rst_i` mid-EXEC → all outputs 0 during reset and ready=1 after release.
